wt_dcache_ship_trainer: RTL and testbench
=========================================

WT_DCACHE_SHIP_TRAINER -- requirements
Module: wt_dcache_ship_trainer

Interface
REQ-001 SHALL have parameter NumSets, default 64, number of tracked dcache sets (power of two, >= 2).
REQ-002 SHALL have parameter NumWays, fixed at 4, dcache associativity.
REQ-003 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  start invalidate sweep of metadata table.
REQ-006 SHALL have port acc_hit_i  input  1  dcache load/store hit this cycle.
REQ-007 SHALL have port acc_set_i  input  log2(NumSets)  set index of hit.
REQ-008 SHALL have port acc_way_i  input  2  way index of hit.
REQ-009 SHALL have port fill_i  input  1  dcache line fill (allocation) this cycle.
REQ-010 SHALL have port fill_set_i  input  log2(NumSets)  set index of fill.
REQ-011 SHALL have port fill_way_i  input  2  victim way being filled.
REQ-012 SHALL have port fill_sig_i  input  14  signature of the incoming line.
REQ-013 SHALL have port pred_hit_o  output  1  hit-training strobe to SHCT predictor.
REQ-014 SHALL have port pred_hit_shct_o  output  14  signature of hit line.
REQ-015 SHALL have port pred_miss_o  output  1  eviction-training strobe to SHCT predictor.
REQ-016 SHALL have port pred_miss_shct_o  output  14  signature of evicted line.
REQ-017 SHALL have port pred_outcome_o  output  1  evicted line's outcome bit (1 = re-referenced).
REQ-018 SHALL have port busy_o  output  1  flush sweep in progress.

Function
REQ-019 SHALL hold per set/way entry: valid (1), sig (14), outcome (1).
REQ-020 SHALL implement FSM states IDLE and FLUSH; IDLE -> FLUSH on flush_i; FLUSH -> IDLE after clearing set NumSets-1.
REQ-021 In FLUSH SHALL clear valid and outcome of all ways of one set per cycle, ascending from 0; sweep takes NumSets cycles.
REQ-022 flush_i asserted during FLUSH SHALL restart sweep at set 0.
REQ-023 busy_o SHALL be 1 exactly while state is FLUSH (registered).
REQ-024 In FLUSH, acc_hit_i and fill_i SHALL be ignored and no training strobes emitted.
REQ-025 In IDLE, acc_hit_i to a valid entry SHALL set its outcome to 1 and, one cycle later, drive pred_hit_o=1 with pred_hit_shct_o = entry sig.
REQ-026 acc_hit_i to an invalid entry SHALL cause no table change and no strobe.
REQ-027 In IDLE, fill_i to a valid entry SHALL, one cycle later, drive pred_miss_o=1, pred_miss_shct_o = old sig, pred_outcome_o = old outcome.
REQ-028 fill_i to an invalid entry SHALL emit no miss strobe.
REQ-029 fill_i SHALL write entry valid=1, sig=fill_sig_i, outcome=0.
REQ-030 Simultaneous hit and fill to the same set/way: fill wins; eviction report uses pre-cycle outcome; no hit strobe.
REQ-031 Simultaneous hit and fill to different entries: both applied; pred_hit_o and pred_miss_o both asserted next cycle.
REQ-032 All outputs SHALL be registered; strobes are single-cycle pulses; payload outputs are 0 when their strobe is 0.
REQ-033 flush_i coincident with hit/fill in IDLE: flush wins, events dropped.

Reset
REQ-034 On rst_ni=0: state IDLE, all valid/outcome bits 0, all outputs 0, immediately and independent of clk_i.
REQ-035 Reset deasserted mid-sweep SHALL leave table fully invalid with busy_o=0; no sweep resumes.

Verification
REQ-036 After reset, fill set 5 way 2 sig 0x1234 -> no pred_miss_o; then fill same entry sig 0x0ABC -> next cycle pred_miss_o=1, pred_miss_shct_o=0x1234, pred_outcome_o=0.
REQ-037 Fill set 3 way 1 sig 0x2001, hit set 3 way 1 -> next cycle pred_hit_o=1, shct 0x2001; later fill same entry -> pred_outcome_o=1.
REQ-038 Same-cycle hit and fill on set 7 way 0 (valid, sig 0x0055, outcome 0) -> pred_miss_o=1, shct 0x0055, outcome 0, pred_hit_o=0.
REQ-039 flush_i with NumSets=64 -> busy_o high 64 cycles; hits during sweep produce no strobes; afterwards all fills report no evictions.
REQ-040 flush_i re-asserted at sweep cycle 30 -> busy_o stays high 64 more cycles.
REQ-041 rst_ni pulsed low asynchronously mid-sweep -> outputs 0 and busy_o=0 before next clock edge.

Source files
------------

// File: rtl/wt_dcache_ship_trainer.sv
// wt_dcache_ship_trainer
// Keeps per-line SHiP metadata (valid, 14-bit signature, re-reference outcome)
// for every set/way of the dcache and turns hits and fills into training
// strobes for the SHCT predictor.
//   clk_i, rst_ni          : clock, async active-low reset
//   flush_i                : start a one-set-per-cycle invalidate sweep
//   acc_hit_i/set/way      : dcache hit; marks the line re-referenced
//   fill_i/set/way/sig     : dcache allocation; reports the evicted line
//   pred_hit_o/_shct_o     : hit-training strobe + signature (registered)
//   pred_miss_o/_shct_o    : eviction-training strobe + signature (registered)
//   pred_outcome_o         : evicted line's outcome bit
//   busy_o                 : sweep in progress
module wt_dcache_ship_trainer #(
  parameter int unsigned NumSets = 64,
  parameter int unsigned NumWays = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       acc_hit_i,
  input  logic [$clog2(NumSets)-1:0] acc_set_i,
  input  logic [1:0]                 acc_way_i,
  input  logic                       fill_i,
  input  logic [$clog2(NumSets)-1:0] fill_set_i,
  input  logic [1:0]                 fill_way_i,
  input  logic [13:0]                fill_sig_i,
  output logic                       pred_hit_o,
  output logic [13:0]                pred_hit_shct_o,
  output logic                       pred_miss_o,
  output logic [13:0]                pred_miss_shct_o,
  output logic                       pred_outcome_o,
  output logic                       busy_o
);
  localparam int unsigned SetW = $clog2(NumSets);

  typedef enum logic {IDLE, FLUSH} state_e;

  state_e                                  state_q, state_d;
  logic [SetW-1:0]                         ptr_q, ptr_d;
  logic [NumSets-1:0][NumWays-1:0]         valid_q, valid_d;
  logic [NumSets-1:0][NumWays-1:0]         outc_q, outc_d;
  logic [NumSets-1:0][NumWays-1:0][13:0]   sig_q, sig_d;
  logic                                    hit_q, hit_d;
  logic [13:0]                             hit_shct_q, hit_shct_d;
  logic                                    miss_q, miss_d;
  logic [13:0]                             miss_shct_q, miss_shct_d;
  logic                                    outcome_q, outcome_d;

  logic same_entry;
  assign same_entry = fill_i && (fill_set_i == acc_set_i) && (fill_way_i == acc_way_i);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    valid_d     = valid_q;
    outc_d      = outc_q;
    sig_d       = sig_q;
    hit_d       = 1'b0;
    hit_shct_d  = '0;
    miss_d      = 1'b0;
    miss_shct_d = '0;
    outcome_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          // flush takes priority; coincident hit/fill are dropped
          state_d = FLUSH;
          ptr_d   = '0;
        end else begin
          if (acc_hit_i && valid_q[acc_set_i][acc_way_i]) begin
            outc_d[acc_set_i][acc_way_i] = 1'b1;
            // a fill to the same line replaces it, so no hit is reported
            if (!same_entry) begin
              hit_d      = 1'b1;
              hit_shct_d = sig_q[acc_set_i][acc_way_i];
            end
          end
          if (fill_i) begin
            // eviction report uses pre-cycle state, ignoring a same-cycle hit
            if (valid_q[fill_set_i][fill_way_i]) begin
              miss_d      = 1'b1;
              miss_shct_d = sig_q[fill_set_i][fill_way_i];
              outcome_d   = outc_q[fill_set_i][fill_way_i];
            end
            valid_d[fill_set_i][fill_way_i] = 1'b1;
            sig_d[fill_set_i][fill_way_i]   = fill_sig_i;
            outc_d[fill_set_i][fill_way_i]  = 1'b0;
          end
        end
      end
      FLUSH: begin
        valid_d[ptr_q] = '0;
        outc_d[ptr_q]  = '0;
        if (flush_i) begin
          ptr_d = '0;
        end else if (ptr_q == SetW'(NumSets - 1)) begin
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      valid_q     <= '0;
      outc_q      <= '0;
      sig_q       <= '0;
      hit_q       <= 1'b0;
      hit_shct_q  <= '0;
      miss_q      <= 1'b0;
      miss_shct_q <= '0;
      outcome_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      valid_q     <= valid_d;
      outc_q      <= outc_d;
      sig_q       <= sig_d;
      hit_q       <= hit_d;
      hit_shct_q  <= hit_shct_d;
      miss_q      <= miss_d;
      miss_shct_q <= miss_shct_d;
      outcome_q   <= outcome_d;
    end
  end

  assign pred_hit_o       = hit_q;
  assign pred_hit_shct_o  = hit_shct_q;
  assign pred_miss_o      = miss_q;
  assign pred_miss_shct_o = miss_shct_q;
  assign pred_outcome_o   = outcome_q;
  assign busy_o           = (state_q == FLUSH);

endmodule

// File: tb/tb_wt_dcache_ship_trainer.sv
module tb_wt_dcache_ship_trainer;
  localparam int NS = 64;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i, acc_hit_i, fill_i;
  logic [5:0]  acc_set_i, fill_set_i;
  logic [1:0]  acc_way_i, fill_way_i;
  logic [13:0] fill_sig_i;
  logic        pred_hit_o, pred_miss_o, pred_outcome_o, busy_o;
  logic [13:0] pred_hit_shct_o, pred_miss_shct_o;

  int n_chk = 0;
  int n_ok  = 0;

  wt_dcache_ship_trainer #(.NumSets(NS), .NumWays(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .acc_hit_i(acc_hit_i), .acc_set_i(acc_set_i), .acc_way_i(acc_way_i),
    .fill_i(fill_i), .fill_set_i(fill_set_i), .fill_way_i(fill_way_i),
    .fill_sig_i(fill_sig_i),
    .pred_hit_o(pred_hit_o), .pred_hit_shct_o(pred_hit_shct_o),
    .pred_miss_o(pred_miss_o), .pred_miss_shct_o(pred_miss_shct_o),
    .pred_outcome_o(pred_outcome_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle_in();
    flush_i = 0; acc_hit_i = 0; fill_i = 0;
    acc_set_i = 0; acc_way_i = 0; fill_set_i = 0; fill_way_i = 0; fill_sig_i = 0;
  endtask

  // one rising edge, then settle 1ns so registered outputs are stable
  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic fill(input int s, input int w, input logic [13:0] sig);
    fill_i = 1; fill_set_i = 6'(s); fill_way_i = 2'(w); fill_sig_i = sig;
  endtask

  task automatic hit(input int s, input int w);
    acc_hit_i = 1; acc_set_i = 6'(s); acc_way_i = 2'(w);
  endtask

  task automatic chk_out(input string tag, input logic h, input logic [13:0] hs,
                         input logic m, input logic [13:0] ms, input logic o);
    chk({tag, ".hit"},      pred_hit_o, h);
    chk({tag, ".hit_shct"}, pred_hit_shct_o, hs);
    chk({tag, ".miss"},     pred_miss_o, m);
    chk({tag, ".miss_shct"},pred_miss_shct_o, ms);
    chk({tag, ".outcome"},  pred_outcome_o, o);
  endtask

  initial begin
    int cnt;
    logic strobe_seen;
    idle_in();
    rst_ni = 0;
    #12;
    chk_out("reset", 0, 0, 0, 0, 0);
    chk("reset.busy", busy_o, 0);
    @(negedge clk_i); rst_ni = 1;
    tick();

    // first fill to an entry: nothing evicted
    fill(5, 2, 14'h1234); tick(); idle_in();
    chk_out("fill_new", 0, 0, 0, 0, 0);
    fill(5, 2, 14'h0ABC); tick(); idle_in();
    chk_out("evict_5_2", 0, 0, 1, 14'h1234, 0);
    tick();
    chk("evict_pulse", pred_miss_o, 0);

    // hit then eviction reports outcome 1
    fill(3, 1, 14'h2001); tick(); idle_in();
    hit(3, 1); tick(); idle_in();
    chk_out("hit_3_1", 1, 14'h2001, 0, 0, 0);
    fill(3, 1, 14'h3000); tick(); idle_in();
    chk_out("evict_3_1", 0, 0, 1, 14'h2001, 1);

    // same-cycle hit and fill to one entry: fill wins
    fill(7, 0, 14'h0055); tick(); idle_in();
    fill(7, 0, 14'h0066); hit(7, 0); tick(); idle_in();
    chk_out("hitfill_same", 0, 0, 1, 14'h0055, 0);

    // hit and fill to different entries: both strobes
    hit(3, 1); fill(5, 2, 14'h0777); tick(); idle_in();
    chk_out("hitfill_diff", 1, 14'h3000, 1, 14'h0ABC, 0);

    // hit to an invalid entry
    hit(9, 3); tick(); idle_in();
    chk_out("hit_invalid", 0, 0, 0, 0, 0);

    // flush with coincident events: flush wins, then count busy cycles
    flush_i = 1; hit(7, 0); fill(3, 1, 14'h0999); tick(); idle_in();
    chk_out("flush_drop", 0, 0, 0, 0, 0);
    cnt = 0; strobe_seen = 0;
    while (busy_o && cnt < 100) begin
      cnt++;
      hit(7, 0); fill(5, 2, 14'h0111);
      tick();
      if (pred_hit_o || pred_miss_o) strobe_seen = 1;
    end
    idle_in();
    chk("flush_busy_cycles", cnt, 64);
    chk("flush_no_strobe", strobe_seen, 0);
    fill(3, 1, 14'h0001); tick(); idle_in();
    chk("post_flush_3_1", pred_miss_o, 0);
    fill(7, 0, 14'h0002); tick(); idle_in();
    chk("post_flush_7_0", pred_miss_o, 0);
    fill(5, 2, 14'h0003); tick(); idle_in();
    chk("post_flush_5_2", pred_miss_o, 0);

    // restart the sweep at sweep cycle 30
    flush_i = 1; tick(); idle_in();
    for (int i = 0; i < 30; i++) tick();
    chk("restart_pre_busy", busy_o, 1);
    flush_i = 1; tick(); flush_i = 0;
    cnt = 0;
    while (busy_o && cnt < 100) begin cnt++; tick(); end
    chk("restart_busy_cycles", cnt, 64);

    // async reset mid-sweep
    fill(40, 3, 14'h0ABC); tick(); idle_in();
    fill(2, 0, 14'h0BAD); tick(); idle_in();
    hit(2, 0); tick(); idle_in();
    chk("pre_rst_hit", pred_hit_o, 1);
    flush_i = 1; tick(); idle_in();
    chk("pre_rst_busy", busy_o, 1);
    #2 rst_ni = 0; #1;
    chk("async_rst_busy", busy_o, 0);
    chk_out("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk_i); rst_ni = 1;
    tick(); tick();
    chk("post_rst_busy", busy_o, 0);
    fill(40, 3, 14'h0001); tick(); idle_in();
    chk("post_rst_40_3", pred_miss_o, 0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
